// File: rtl/cordic_rotation.sv
// ----------------------------------------------------------------------------
// cordic_rotation
//
// Iterative rotation-mode CORDIC: turns a polar pair (norm, angle) back into
// rectangular coordinates, one micro-rotation per clock. It takes the
// norm/angle outputs of the vectoring-mode stage directly.
//
// Optional feature macro: CORDIC_ROT_GAIN_COMP_EN
//   defined   : norm is pre-scaled by 1/K (x * 39797 >> 16) on load, so the
//               outputs are the true norm*cos / norm*sin.
//   undefined : norm is loaded unscaled, no multiplier, and the outputs carry
//               the CORDIC gain K ~= 1.64676.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   in_valid  in   norm/angle valid; accepted only when idle
//   norm      in   [31:0] unsigned magnitude
//   angle     in   [31:0] signed Q16.16 degrees, [-180, +180]
//   busy      out  high while a sample is in flight
//   out_valid out  one-cycle pulse when x_out/y_out are updated
//   x_out     out  [31:0] signed, saturated norm*cos(angle)
//   y_out     out  [31:0] signed, saturated norm*sin(angle)
// ----------------------------------------------------------------------------
module cordic_rotation #(
    parameter int ITER = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] norm,
    input  logic [31:0] angle,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] x_out,
    output logic [31:0] y_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 90 and 180 degrees in Q16.16, widened to the z register width.
    localparam logic signed [33:0] DEG90  = 34'sd5898240;
    localparam logic signed [33:0] DEG180 = 34'sd11796480;

    // round(atan(2^-i) * 180/pi * 2^16)
    function automatic logic signed [33:0] atan_lookup(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lookup = 34'sd2949120;
            5'd1:    atan_lookup = 34'sd1740967;
            5'd2:    atan_lookup = 34'sd919879;
            5'd3:    atan_lookup = 34'sd466945;
            5'd4:    atan_lookup = 34'sd234379;
            5'd5:    atan_lookup = 34'sd117304;
            5'd6:    atan_lookup = 34'sd58666;
            5'd7:    atan_lookup = 34'sd29335;
            5'd8:    atan_lookup = 34'sd14668;
            5'd9:    atan_lookup = 34'sd7334;
            5'd10:   atan_lookup = 34'sd3667;
            5'd11:   atan_lookup = 34'sd1833;
            5'd12:   atan_lookup = 34'sd917;
            5'd13:   atan_lookup = 34'sd458;
            5'd14:   atan_lookup = 34'sd229;
            5'd15:   atan_lookup = 34'sd115;
            5'd16:   atan_lookup = 34'sd57;
            5'd17:   atan_lookup = 34'sd29;
            5'd18:   atan_lookup = 34'sd14;
            5'd19:   atan_lookup = 34'sd7;
            5'd20:   atan_lookup = 34'sd4;
            5'd21:   atan_lookup = 34'sd2;
            5'd22:   atan_lookup = 34'sd1;
            default: atan_lookup = 34'sd0;
        endcase
    endfunction

    // Clamp a 35-bit signed value into the 32-bit signed output range.
    function automatic logic [31:0] sat32(input logic signed [34:0] v);
        if (v > 35'sd2147483647) begin
            sat32 = 32'h7FFF_FFFF;
        end else if (v < -35'sd2147483648) begin
            sat32 = 32'h8000_0000;
        end else begin
            sat32 = v[31:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic        [31:0] x_out_q, x_out_d;
    logic        [31:0] y_out_q, y_out_d;
    logic signed [34:0] x_q, x_d;
    logic signed [34:0] y_q, y_d;
    logic signed [33:0] z_q, z_d;
    logic        [4:0]  iter_q, iter_d;
    logic               neg_q, neg_d;

    logic signed [33:0] z_in_s;
    logic signed [33:0] z_fold_s;
    logic               neg_fold_s;
    logic signed [34:0] x_load_s;
    logic signed [34:0] x_fin_s;
    logic signed [34:0] y_fin_s;

`ifdef CORDIC_ROT_GAIN_COMP_EN
    logic [47:0] gain_prod_s;
    assign gain_prod_s = {16'd0, norm} * 48'd39797;
    assign x_load_s    = 35'(gain_prod_s >> 16);
`else
    assign x_load_s    = {3'b000, norm};
`endif

    // Fold the input angle into [-90, +90]; the half-turn is restored by
    // negating the result at the end.
    always_comb begin
        z_in_s     = {{2{angle[31]}}, angle};
        z_fold_s   = z_in_s;
        neg_fold_s = 1'b0;
        if (z_in_s > DEG90) begin
            z_fold_s   = z_in_s - DEG180;
            neg_fold_s = 1'b1;
        end else if (z_in_s < -DEG90) begin
            z_fold_s   = z_in_s + DEG180;
            neg_fold_s = 1'b1;
        end else begin
            z_fold_s   = z_in_s;
            neg_fold_s = 1'b0;
        end
    end

    // Apply the half-turn flag to the final vector before saturation.
    always_comb begin
        if (neg_q) begin
            x_fin_s = -x_q;
            y_fin_s = -y_q;
        end else begin
            x_fin_s = x_q;
            y_fin_s = y_q;
        end
    end

    // Next-state logic: load, micro-rotations, and output registration.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        neg_d       = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !busy_q) begin
                    x_d     = x_load_s;
                    y_d     = 35'sd0;
                    z_d     = z_fold_s;
                    neg_d   = neg_fold_s;
                    iter_d  = 5'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                // d = +1 when z >= 0; x, y, z all use the previous values.
                if (z_q[33] == 1'b0) begin
                    x_d = x_q - (y_q >>> iter_q);
                    y_d = y_q + (x_q >>> iter_q);
                    z_d = z_q - atan_lookup(iter_q);
                end else begin
                    x_d = x_q + (y_q >>> iter_q);
                    y_d = y_q - (x_q >>> iter_q);
                    z_d = z_q + atan_lookup(iter_q);
                end
                if (iter_q == 5'(ITER - 1)) begin
                    state_d = DONE;
                end else begin
                    iter_d  = iter_q + 5'd1;
                end
            end
            DONE: begin
                x_out_d     = sat32(x_fin_s);
                y_out_d     = sat32(y_fin_s);
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            x_out_q     <= 32'd0;
            y_out_q     <= 32'd0;
            x_q         <= 35'sd0;
            y_q         <= 35'sd0;
            z_q         <= 34'sd0;
            iter_q      <= 5'd0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            neg_q       <= neg_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;

endmodule

// File: tb/tb_cordic_rotation.sv
// ----------------------------------------------------------------------------
// tb_cordic_rotation
//
// Directed bench for cordic_rotation (ITER = 16). Expected values are the
// hand-derived norm*cos / norm*sin, scaled by the CORDIC gain when the
// gain-compensation macro is not defined, with a +-4 tolerance.
// ----------------------------------------------------------------------------
module tb_cordic_rotation;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] norm;
    logic [31:0] angle;
    logic        busy;
    logic        out_valid;
    logic [31:0] x_out;
    logic [31:0] y_out;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

`ifdef CORDIC_ROT_GAIN_COMP_EN
    localparam real         GAIN     = 1.0;
    localparam logic [31:0] MID_NORM = 32'd65536;
`else
    localparam real         GAIN     = 1.6467603;
    localparam logic [31:0] MID_NORM = 32'd39797;
`endif
    localparam real R2 = 0.70710678;

    cordic_rotation #(.ITER(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .norm      (norm),
        .angle     (angle),
        .busy      (busy),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input real exp);
        real o;
        o = $itor($signed(obs));
        n_checks++;
        assert ((o >= exp - 4.0) && (o <= exp + 4.0)) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0f +-4", tag, $signed(obs), exp);
        end
    endtask

    // Present one sample from a negedge; returns the cycle count after the
    // acceptance edge.
    task automatic send(input logic [31:0] n, input logic [31:0] a, output int acc);
        @(negedge clock);
        in_valid = 1'b1;
        norm     = n;
        angle    = a;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        acc      = cyc;
        chk_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for out_valid; returns cycles since 'acc', or -1.
    task automatic wait_ov(input int acc, output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    // Count out_valid pulses over a window of cycles.
    task automatic count_ov(input int ncyc, output int pulses);
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) pulses++;
        end
    endtask

    initial begin
        int acc;
        int lat;
        int t1;
        int pulses;

        reset    = 1'b1;
        in_valid = 1'b0;
        norm     = 32'd0;
        angle    = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk_eq("reset_busy",      {31'd0, busy},      32'd0);
        chk_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk_eq("reset_x_out",     x_out,              32'd0);
        chk_eq("reset_y_out",     y_out,              32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 90 degrees: latency and basic result.
        send(32'd1000, 32'h005A_0000, acc);
        wait_ov(acc, lat);
        chk_eq("lat_90", lat, 32'd17);
        chk_near("x_90", x_out, 0.0);
        chk_near("y_90", y_out, 1000.0 * GAIN);
        @(posedge clock);
        #1;
        chk_eq("ov_one_cycle", {31'd0, out_valid}, 32'd0);

        // +180 folds to 0 with negate.
        send(32'd1000, 32'h00B4_0000, acc);
        wait_ov(acc, lat);
        chk_eq("lat_180", lat, 32'd17);
        chk_near("x_180", x_out, -1000.0 * GAIN);
        chk_near("y_180", y_out, 0.0);

        // -135 folds to +45 with negate.
        send(32'd1000, 32'hFF79_0000, acc);
        wait_ov(acc, lat);
        chk_near("x_m135", x_out, -1000.0 * GAIN * R2);
        chk_near("y_m135", y_out, -1000.0 * GAIN * R2);

        // Sample presented while busy is dropped.
        send(32'd1000, 32'h0000_0000, acc);
        repeat (4) @(posedge clock);
        #1;
        in_valid = 1'b1;
        norm     = 32'd500;
        angle    = 32'h005A_0000;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_ov(acc, lat);
        chk_eq("lat_busy_drop", lat, 32'd17);
        chk_near("x_0", x_out, 1000.0 * GAIN);
        chk_near("y_0", y_out, 0.0);
        count_ov(25, pulses);
        chk_eq("dropped_no_pulse", pulses, 32'd0);
        chk_near("x_0_held", x_out, 1000.0 * GAIN);

        // -45 degrees, then back-to-back accept during the out_valid cycle.
        send(MID_NORM, 32'hFFD3_0000, acc);
        wait_ov(acc, lat);
        chk_eq("lat_m45", lat, 32'd17);
        chk_near("x_m45", x_out, $itor(MID_NORM) * GAIN * R2);
        chk_near("y_m45", y_out, -$itor(MID_NORM) * GAIN * R2);
        t1       = cyc;
        in_valid = 1'b1;
        norm     = 32'd1000;
        angle    = 32'hFF4C_0000;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk_eq("b2b_busy", {31'd0, busy}, 32'd1);
        wait_ov(t1, lat);
        chk_eq("b2b_spacing", lat, 32'd18);
        chk_near("x_m180", x_out, -1000.0 * GAIN);
        chk_near("y_m180", y_out, 0.0);

        // Reset in the middle of RUN aborts the sample.
        send(32'd1000, 32'h002D_0000, acc);
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_eq("midrst_busy",      {31'd0, busy},      32'd0);
        chk_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_eq("midrst_x_out",     x_out,              32'd0);
        chk_eq("midrst_y_out",     y_out,              32'd0);
        @(negedge clock);
        reset = 1'b0;
        count_ov(25, pulses);
        chk_eq("midrst_no_pulse", pulses, 32'd0);

        // Reset wins over a simultaneous in_valid.
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b1;
        norm     = 32'd1000;
        angle    = 32'd0;
        @(posedge clock);
        #1;
        chk_eq("rst_vs_valid_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk_eq("rst_vs_valid_idle", {31'd0, busy}, 32'd0);

        // Saturation at both ends of the output range.
        send(32'hFFFF_FFFF, 32'h0000_0000, acc);
        wait_ov(acc, lat);
        chk_eq("lat_sat_pos", lat, 32'd17);
        chk_eq("x_sat_pos", x_out, 32'h7FFF_FFFF);
        send(32'hFFFF_FFFF, 32'h00B4_0000, acc);
        wait_ov(acc, lat);
        chk_eq("x_sat_neg", x_out, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
